// File: rtl/verisparse_pkg.sv
// verisparse shared types: fixed-point words, inner-product sequencer states,
// and saturation / magnitude helpers.
`default_nettype none

package verisparse;

  localparam int SIGNAL_SIZE_DEFAULT     = 16;
  localparam int DICTIONARY_SIZE_DEFAULT = 64;
  localparam int FP_Q_DEFAULT            = 15;
  localparam int FP_DATA_BUS_WIDTH       = 32;
  localparam int VS_ACC_WIDTH            = 64;

  typedef logic signed [31:0]             fp_32_t;
  typedef logic signed [VS_ACC_WIDTH-1:0] fp_64_t;

  typedef enum logic [2:0] {
    VS_IPS_IDLE  = 3'd0,
    VS_IPS_RUN   = 3'd1,
    VS_IPS_FLUSH = 3'd2,
    VS_IPS_WRITE = 3'd3,
    VS_IPS_DONE  = 3'd4
  } vs_ips_state_t;

  localparam fp_64_t VS_FP32_MAX_64 = 64'sh0000_0000_7FFF_FFFF;
  localparam fp_64_t VS_FP32_MIN_64 = -64'sh0000_0000_8000_0000;

  // Arithmetic (floor) shift down by q, then clamp into the signed 32-bit range.
  function automatic fp_32_t vs_sat_fixed(input fp_64_t value, input int q);
    fp_64_t shifted;
    shifted = value >>> q;
    if (shifted > VS_FP32_MAX_64)
      return 32'sh7FFF_FFFF;
    else if (shifted < VS_FP32_MIN_64)
      return 32'sh8000_0000;
    else
      return shifted[31:0];
  endfunction

  // 33 bits so that |0x80000000| is representable.
  function automatic logic [32:0] vs_abs33(input fp_32_t value);
    logic [32:0] ext;
    ext = {value[31], value};
    return value[31] ? (~ext + 33'd1) : ext;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vs_inner_product_sequencer_mac.sv
// Registered signed 32x32 multiply-accumulate into a 64-bit accumulator.
`default_nettype none

module vs_fixed_mac
  import verisparse::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   enable,
  input  fp_32_t a,
  input  fp_32_t b,
  output fp_64_t acc_next
);

  fp_64_t acc;
  fp_64_t product;

  assign product  = fp_64_t'(a) * fp_64_t'(b);
  assign acc_next = acc + product;

  always_ff @(posedge clk) begin
    if (reset || clear)
      acc <= '0;
    else if (enable)
      acc <= acc_next;
  end

endmodule

`default_nettype wire

// File: rtl/vs_inner_product_sequencer.sv
// Correlation step of greedy pursuit: x[n] = <d_n, y> for every dictionary
// column, written saturated to x RAM while tracking the largest |x[n]|.
`default_nettype none

module vs_inner_product_sequencer
  import verisparse::*;
#(
  parameter  int M = SIGNAL_SIZE_DEFAULT,
  parameter  int N = DICTIONARY_SIZE_DEFAULT,
  parameter  int Q = FP_Q_DEFAULT,
  parameter  int W = FP_DATA_BUS_WIDTH,
  localparam int SIGNAL_ADDR_WIDTH         = $clog2(M),
  localparam int DICTIONARY_ADDR_WIDTH     = $clog2(M * N),
  localparam int REPRESENTATION_ADDR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  output logic                                 busy,
  output logic                                 done,
  output logic [SIGNAL_ADDR_WIDTH-1:0]         y_read_addr,
  input  logic [W-1:0]                         y_read_data,
  output logic [DICTIONARY_ADDR_WIDTH-1:0]     dict_read_addr,
  input  logic [W-1:0]                         dict_read_data,
  output logic                                 x_write_enable,
  output logic [REPRESENTATION_ADDR_WIDTH-1:0] x_write_addr,
  output logic [W-1:0]                         x_write_data,
  output logic [REPRESENTATION_ADDR_WIDTH-1:0] max_index,
  output logic [W-1:0]                         max_value
);

  vs_ips_state_t                       state;
  logic [SIGNAL_ADDR_WIDTH-1:0]         m;
  logic [REPRESENTATION_ADDR_WIDTH-1:0] n;
  logic                                 valid_d;

  fp_32_t y_sample;
  fp_32_t d_sample;
  fp_64_t acc_next;
  fp_32_t sat_result;
  logic   mac_clear;

  assign y_sample   = fp_32_t'(y_read_data);
  assign d_sample   = fp_32_t'(dict_read_data);
  assign mac_clear  = (state == VS_IPS_IDLE) || (state == VS_IPS_WRITE) ||
                      (state == VS_IPS_DONE);
  // In FLUSH the last product is still being added, so take the sum-in-flight.
  assign sat_result = vs_sat_fixed(acc_next, Q);

  vs_fixed_mac u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear    (mac_clear),
    .enable   (valid_d),
    .a        (y_sample),
    .b        (d_sample),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= VS_IPS_IDLE;
      m              <= '0;
      n              <= '0;
      valid_d        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      y_read_addr    <= '0;
      dict_read_addr <= '0;
      x_write_enable <= 1'b0;
      x_write_addr   <= '0;
      x_write_data   <= '0;
      max_index      <= '0;
      max_value      <= '0;
    end else begin
      x_write_enable <= 1'b0;
      done           <= 1'b0;
      valid_d        <= (state == VS_IPS_RUN) && !abort;

      case (state)
        VS_IPS_IDLE: begin
          if (start) begin
            state          <= VS_IPS_RUN;
            busy           <= 1'b1;
            m              <= '0;
            n              <= '0;
            y_read_addr    <= '0;
            dict_read_addr <= '0;
            max_index      <= '0;
            max_value      <= '0;
          end
        end

        VS_IPS_RUN: begin
          if (abort) begin
            state <= VS_IPS_IDLE;
            busy  <= 1'b0;
          end else if (m == SIGNAL_ADDR_WIDTH'(M - 1)) begin
            state <= VS_IPS_FLUSH;
          end else begin
            m              <= m + 1'b1;
            y_read_addr    <= m + 1'b1;
            dict_read_addr <= dict_read_addr + 1'b1;
          end
        end

        VS_IPS_FLUSH: begin
          if (abort) begin
            state <= VS_IPS_IDLE;
            busy  <= 1'b0;
          end else begin
            state          <= VS_IPS_WRITE;
            x_write_enable <= 1'b1;
            x_write_addr   <= n;
            x_write_data   <= sat_result;
          end
        end

        VS_IPS_WRITE: begin
          // Strict compare: on a tie the earlier (lower) column is kept.
          if (vs_abs33(x_write_data) > vs_abs33(max_value)) begin
            max_index <= n;
            max_value <= x_write_data;
          end
          m <= '0;
          if (abort) begin
            state <= VS_IPS_IDLE;
            busy  <= 1'b0;
          end else if (n == REPRESENTATION_ADDR_WIDTH'(N - 1)) begin
            state <= VS_IPS_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state          <= VS_IPS_RUN;
            n              <= n + 1'b1;
            y_read_addr    <= '0;
            dict_read_addr <= dict_read_addr + 1'b1;
          end
        end

        VS_IPS_DONE: state <= VS_IPS_IDLE;

        default: begin
          state <= VS_IPS_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vs_inner_product_sequencer.sv
// Directed bench for vs_inner_product_sequencer with behavioural sync RAMs.
`default_nettype none

module tb_vs_inner_product_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [3:0]  y_read_addr;
  logic [31:0] y_read_data;
  logic [9:0]  dict_read_addr;
  logic [31:0] dict_read_data;
  logic        x_write_enable;
  logic [5:0]  x_write_addr;
  logic [31:0] x_write_data;
  logic [5:0]  max_index;
  logic [31:0] max_value;

  logic [31:0] y_mem [16];
  logic [31:0] d_mem [1024];
  logic [31:0] x_mem [64];
  int          wr_count   = 0;
  int          done_count = 0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vs_inner_product_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .y_read_addr    (y_read_addr),
    .y_read_data    (y_read_data),
    .dict_read_addr (dict_read_addr),
    .dict_read_data (dict_read_data),
    .x_write_enable (x_write_enable),
    .x_write_addr   (x_write_addr),
    .x_write_data   (x_write_data),
    .max_index      (max_index),
    .max_value      (max_value)
  );

  always @(posedge clk) begin
    y_read_data    <= y_mem[y_read_addr];
    dict_read_data <= d_mem[dict_read_addr];
  end

  always @(posedge clk) begin
    if (x_write_enable) begin
      x_mem[x_write_addr] <= x_write_data;
      wr_count            <= wr_count + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mems;
    for (int i = 0; i < 16; i++) y_mem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) d_mem[i] = 32'h0;
  endtask

  task automatic load_hot_column;
    clear_mems();
    for (int i = 0; i < 16; i++) begin
      y_mem[i]        = 32'h0000_8000;
      d_mem[5*16 + i] = 32'h0000_0800;
    end
  endtask

  // Returns the cycle (1 = first cycle after start is sampled) in which done
  // is high, or 0 if it never came within the budget.
  task automatic run_full(output int dcyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    dcyc  = 0;
    for (int cyc = 1; cyc < 1400; cyc++) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic count_not_equal(input logic [31:0] value, output int bad);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (x_mem[i] !== value) bad++;
  endtask

  task automatic check_hot_result(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (i != 5 && x_mem[i] !== 32'h0) bad++;
    chk({tag, "_x5"}, x_mem[5], 32'h0000_8000);
    chk({tag, "_others_zero"}, bad, 0);
    chk({tag, "_max_index"}, max_index, 5);
    chk({tag, "_max_value"}, max_value, 32'h0000_8000);
  endtask

  initial begin
    int dc;
    int w0;
    int d0;
    int bad;

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    clear_mems();
    repeat (2) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_we", x_write_enable, 0);
    chk("reset_addrs", {y_read_addr, dict_read_addr, x_write_addr}, 0);
    chk("reset_wdata", x_write_data, 0);
    chk("reset_max", {max_index, max_value}, 0);
    reset = 1'b0;
    tick();

    // Single hot column: 16 * (1.0 * 1/16) = 1.0 in column 5.
    load_hot_column();
    w0 = wr_count;
    run_full(dc);
    chk("hot_done_cycle", dc, 1153);
    chk("hot_busy_in_done", busy, 0);
    chk("hot_write_count", wr_count - w0, 64);
    check_hot_result("hot");
    tick();
    chk("hot_done_one_cycle", done, 0);

    // Tie in magnitude with opposite signs: lower index wins.
    clear_mems();
    for (int i = 0; i < 16; i++) y_mem[i] = 32'h0000_8000;
    d_mem[3*16] = 32'hFFFF_C000;
    d_mem[9*16] = 32'h0000_4000;
    run_full(dc);
    chk("tie_x3", x_mem[3], 32'hFFFF_C000);
    chk("tie_x9", x_mem[9], 32'h0000_4000);
    chk("tie_max_index", max_index, 3);
    chk("tie_max_value", max_value, 32'hFFFF_C000);
    tick();

    // Saturation on four rows: 4 * 2^60 = 2^62 still fits the 64-bit
    // accumulator (all 16 rows would wrap it to zero).
    clear_mems();
    for (int i = 0; i < 4; i++) begin
      y_mem[i] = 32'h4000_0000;
      for (int j = 0; j < 64; j++) d_mem[j*16 + i] = 32'h4000_0000;
    end
    run_full(dc);
    count_not_equal(32'h7FFF_FFFF, bad);
    chk("sat_pos_all", bad, 0);
    chk("sat_pos_x0", x_mem[0], 32'h7FFF_FFFF);
    for (int i = 0; i < 4; i++) y_mem[i] = 32'hC000_0000;
    tick();
    run_full(dc);
    count_not_equal(32'h8000_0000, bad);
    chk("sat_neg_all", bad, 0);
    chk("sat_neg_max", {max_index, max_value}, {6'd0, 32'h8000_0000});
    tick();

    // -1 LSB^2 floors to -1, not 0.
    clear_mems();
    y_mem[0] = 32'hFFFF_FFFF;
    d_mem[0] = 32'h0000_0001;
    run_full(dc);
    chk("floor_x0", x_mem[0], 32'hFFFF_FFFF);
    chk("floor_max", {max_index, max_value}, {6'd0, 32'hFFFF_FFFF});
    tick();

    // Abort in cycle 100 (column 5, columns 0..4 already written).
    load_hot_column();
    w0 = wr_count;
    d0 = done_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy_after", busy, 0);
    chk("abort_write_count", wr_count - w0, 5);
    chk("abort_no_done", done_count - d0, 0);

    // Immediate restart gives a full, correct run.
    w0 = wr_count;
    run_full(dc);
    chk("restart_done_cycle", dc, 1153);
    chk("restart_write_count", wr_count - w0, 64);
    check_hot_result("restart");
    tick();

    // Reset in cycle 40 of a run.
    w0 = wr_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (39) tick();
    reset = 1'b1;
    tick();
    chk("midreset_busy_done_we", {busy, done, x_write_enable}, 0);
    chk("midreset_addrs", {y_read_addr, dict_read_addr, x_write_addr}, 0);
    chk("midreset_data_max", {x_write_data, max_index, max_value}, 0);
    reset = 1'b0;
    repeat (30) tick();
    chk("midreset_stays_idle", busy, 0);
    chk("midreset_writes", wr_count - w0, 2);

    // Stray start pulses while busy and during the DONE cycle.
    w0 = wr_count;
    d0 = done_count;
    dc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 1400; cyc++) begin
      start = (cyc == 50);
      if (done) begin
        dc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        break;
      end
      tick();
    end
    start = 1'b0;
    chk("stray_done_cycle", dc, 1153);
    repeat (40) tick();
    chk("stray_no_second_run", busy, 0);
    chk("stray_done_count", done_count - d0, 1);
    chk("stray_write_count", wr_count - w0, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
